baud_controller: RTL and testbench

//  - UART timing generator: emits a one-cycle sample_ENABLE strobe at OVERSAMPLE x the selected baud rate.
//  - Shared by the UART transmitter and receiver; the receiver samples on every strobe, the transmitter

---
 rtl/baud_pkg.sv | 41 ++++
 rtl/baud_controller_rom.sv | 29 ++
 rtl/baud_controller.sv | 100 ++++++++++
 tb/tb_baud_controller.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/baud_pkg.sv
// ============================================================================
//  Module      : baud_pkg
//  Description : Baud rate table and divisor helpers for baud_controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package baud_pkg;

  localparam int unsigned BAUD_CLK_HZ_DEFAULT = 100_000_000;
  localparam int unsigned BAUD_OS_DEFAULT     = 16;

  localparam int unsigned BAUD_RATES [8] = '{
    300, 1200, 4800, 9600, 19200, 38400, 57600, 115200
  };

  // Rounded divisor: (clk + os*baud/2) / (os*baud), done in 64 bits.
  function automatic int unsigned baud_divisor(input int unsigned clk_hz,
                                               input int unsigned os,
                                               input logic [2:0]  sel);
    longint unsigned den;
    den = 64'(os) * 64'(BAUD_RATES[sel]);
    return 32'((64'(clk_hz) + den / 2) / den);
  endfunction

  function automatic int unsigned baud_max_divisor(input int unsigned clk_hz,
                                                   input int unsigned os);
    int unsigned m;
    m = 0;
    for (int i = 0; i < 8; i++) begin
      if (baud_divisor(clk_hz, os, 3'(i)) > m) m = baud_divisor(clk_hz, os, 3'(i));
    end
    return m;
  endfunction

  localparam int unsigned BAUD_MAX_DIVISOR =
    baud_max_divisor(BAUD_CLK_HZ_DEFAULT, BAUD_OS_DEFAULT);

endpackage

`default_nettype wire

// File: rtl/baud_controller_rom.sv
// ============================================================================
//  Module      : baud_divisor_rom
//  Description : Constant lookup of baud code to divisor-minus-one.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module baud_divisor_rom
  import baud_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = BAUD_CLK_HZ_DEFAULT,
  parameter int unsigned OVERSAMPLE  = BAUD_OS_DEFAULT,
  parameter int unsigned CNT_W       = 16
) (
  input  logic [2:0]       i_sel,
  output logic [CNT_W-1:0] o_div_m1
);

  logic [CNT_W-1:0] w_rom [8];

  for (genvar g = 0; g < 8; g++) begin : g_rom
    assign w_rom[g] = CNT_W'(baud_divisor(CLK_FREQ_HZ, OVERSAMPLE, 3'(g)) - 1);
  end

  assign o_div_m1 = w_rom[i_sel];

endmodule

`default_nettype wire

// File: rtl/baud_controller.sv
// ============================================================================
//  Module      : baud_controller
//  Description : UART oversample strobe generator; optional bit tick output
//                enabled by defining BAUD_BIT_TICK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module baud_controller
  import baud_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = BAUD_CLK_HZ_DEFAULT,
  parameter int unsigned OVERSAMPLE  = BAUD_OS_DEFAULT,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  output logic       sample_ENABLE
`ifdef BAUD_BIT_TICK_EN
  ,
  output logic       bit_ENABLE
`endif
);

  if (64'(baud_max_divisor(CLK_FREQ_HZ, OVERSAMPLE)) > (64'd1 << CNT_W)) begin : g_cnt_w_check
    $error("baud_controller: CNT_W too narrow for the largest divisor");
  end

  // Declaration values give the zero power-up state when reset is never used.
  logic [CNT_W-1:0] r_cnt    = '0;
  logic [2:0]       r_sel_q  = '0;
  logic             r_sample = 1'b0;

  logic [CNT_W-1:0] w_div_m1;
  logic             w_sel_change;
  logic             w_wrap;

  baud_divisor_rom #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .OVERSAMPLE  (OVERSAMPLE),
    .CNT_W       (CNT_W)
  ) u_rom (
    .i_sel    (r_sel_q),
    .o_div_m1 (w_div_m1)
  );

  assign w_sel_change = (baud_select != r_sel_q);
  assign w_wrap       = (r_cnt == w_div_m1);

  // A selection change wins over a wrap landing on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_sel_q  <= '0;
      r_sample <= 1'b0;
    end else begin
      r_sel_q <= baud_select;
      if (w_sel_change) begin
        r_cnt    <= '0;
        r_sample <= 1'b0;
      end else if (w_wrap) begin
        r_cnt    <= '0;
        r_sample <= 1'b1;
      end else begin
        r_cnt    <= r_cnt + CNT_W'(1);
        r_sample <= 1'b0;
      end
    end
  end

  assign sample_ENABLE = r_sample;

`ifdef BAUD_BIT_TICK_EN
  localparam logic [3:0] c_tick_last = 4'(OVERSAMPLE - 1);

  logic [3:0] r_tick_cnt = '0;
  logic       r_bit      = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_bit      <= 1'b0;
    end else if (w_sel_change) begin
      r_tick_cnt <= '0;
      r_bit      <= 1'b0;
    end else if (w_wrap) begin
      r_bit      <= (r_tick_cnt == c_tick_last);
      r_tick_cnt <= (r_tick_cnt == c_tick_last) ? 4'd0 : r_tick_cnt + 4'd1;
    end else begin
      r_bit <= 1'b0;
    end
  end

  assign bit_ENABLE = r_bit;
`endif

endmodule

`default_nettype wire

// File: tb/tb_baud_controller.sv
// ============================================================================
//  Module      : tb_baud_controller
//  Description : Self-checking bench for baud_controller (both builds).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_baud_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] baud_select;
  logic       sample_ENABLE;
`ifdef BAUD_BIT_TICK_EN
  logic       bit_ENABLE;
`endif

  int checks      = 0;
  int failures    = 0;
  int fail_prints = 0;

  baud_controller dut (
    .clk           (clk),
    .reset         (reset),
    .baud_select   (baud_select),
    .sample_ENABLE (sample_ENABLE)
`ifdef BAUD_BIT_TICK_EN
    ,
    .bit_ENABLE    (bit_ENABLE)
`endif
  );

  always #5 clk = ~clk;

  // Model: edges elapsed since the last reset release or selection change.
  int bauds [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
  int         m_since = 0;
  logic [2:0] m_sel   = 3'b000;

  function automatic int n_of(input logic [2:0] s);
    int b;
    b = bauds[s];
    return (100_000_000 + 8 * b) / (16 * b);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_since <= 0;
      m_sel   <= 3'b000;
    end else if (baud_select != m_sel) begin
      m_sel   <= baud_select;
      m_since <= 0;
    end else begin
      m_since <= m_since + 1;
    end
  end

  always @(negedge clk) begin
    logic exp_s;
    exp_s = (m_since > 0) && (m_since % n_of(m_sel) == 0);
    checks++;
    if (sample_ENABLE !== exp_s) begin
      failures++;
      if (fail_prints < 20) begin
        fail_prints++;
        $display("FAIL sample_ENABLE t=%0t actual=%b expected=%b", $time, sample_ENABLE, exp_s);
      end
    end
`ifdef BAUD_BIT_TICK_EN
    begin
      logic exp_b;
      exp_b = (m_since > 0) && (m_since % (16 * n_of(m_sel)) == 0);
      checks++;
      if (bit_ENABLE !== exp_b) begin
        failures++;
        if (fail_prints < 20) begin
          fail_prints++;
          $display("FAIL bit_ENABLE t=%0t actual=%b expected=%b", $time, bit_ENABLE, exp_b);
        end
      end
    end
`endif
  end

  function automatic void check_lit(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endfunction

  // Counts negedges (one per rising edge) until the strobe is seen.
  task automatic wait_strobe(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_ENABLE && n < budget);
    if (!sample_ENABLE) begin
      checks++;
      failures++;
      $display("FAIL strobe_timeout actual=none expected=strobe within %0d", budget);
    end
  endtask

`ifdef BAUD_BIT_TICK_EN
  task automatic wait_bit(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bit_ENABLE && n < budget);
    if (!bit_ENABLE) begin
      checks++;
      failures++;
      $display("FAIL bit_timeout actual=none expected=bit tick within %0d", budget);
    end
  endtask
`endif

  int c_div [8] = '{20833, 5208, 1302, 651, 326, 163, 109, 54};

  initial begin
    int n;
    reset       = 1'b0;
    baud_select = 3'b111;

    // Power-up with no reset: registered select 000->111 counts as a change on edge 1.
    wait_strobe(200, n);  check_lit("powerup_first", n, 55);
    wait_strobe(200, n);  check_lit("powerup_interval", n, 54);

    // Reset asserted while the strobe is high must drop it at once.
    #2 reset = 1'b1;
    baud_select = 3'b000;
    #1 check_lit("reset_clears_strobe", int'(sample_ENABLE), 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    wait_strobe(21000, n); check_lit("sel0_first", n, 20833);
    @(negedge clk);        check_lit("strobe_width", int'(sample_ENABLE), 0);
    wait_strobe(21000, n); check_lit("sel0_interval_after_width", n, 20832);

    // Asynchronous reset mid-count.
    repeat (100) @(negedge clk);
    check_lit("cnt_before_reset", int'(dut.r_cnt), 100);
    #2 reset = 1'b1;
    #1 check_lit("reset_clears_cnt", int'(dut.r_cnt), 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    wait_strobe(21000, n); check_lit("after_midreset_first", n, 20833);

    for (int s = 1; s < 8; s++) begin
      baud_select = 3'(s);
      wait_strobe(6000, n); check_lit($sformatf("sweep%0d_first", s), n, c_div[s] + 1);
      wait_strobe(6000, n); check_lit($sformatf("sweep%0d_interval", s), n, c_div[s]);
    end

    // Change 011->111 mid-count.
    baud_select = 3'b011;
    wait_strobe(1000, n); check_lit("sel3_first", n, 652);
    repeat (300) @(negedge clk);
    baud_select = 3'b111;
    wait_strobe(1000, n); check_lit("midcount_change", n, 55);

    // Change lands on the wrap edge: that strobe is suppressed.
    repeat (53) @(negedge clk);
    baud_select = 3'b110;
    wait_strobe(1000, n); check_lit("coincident_change", n, 110);

    // Reset restores select 000, so a held 111 is seen as a change after release.
    baud_select = 3'b111;
    wait_strobe(1000, n); check_lit("sel7_again", n, 55);
    #2 reset = 1'b1;
    #1 check_lit("reset_clears_strobe2", int'(sample_ENABLE), 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    wait_strobe(1000, n); check_lit("sel7_after_reset", n, 55);

`ifdef BAUD_BIT_TICK_EN
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    wait_bit(2000, n); check_lit("bit_first", n, 865);
    check_lit("bit_with_strobe", int'(sample_ENABLE), 1);
    wait_bit(2000, n); check_lit("bit_interval", n, 864);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
